lsu_bus_master: RTL

- Load/store initiator between the pipeline MEM stage and the word-wide data-memory bus; the memory side is the responder.
- Accepts one CPU access at a time: word, half or byte; load or store; signed or unsigned load.
- Checks alignment, converts the access into a word-aligned bus request with byte enables and lane-replicated write data, and returns an extended load result or a store acknowledge.
- Adds a bounded wait with timeout so a stalled responder cannot hang the pipeline.

---
 rtl/lsu_bus_master.sv | 106 ++++++++++
 1 files changed

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-outstanding load/store initiator with alignment check, lane steering and timeout
module lsu_bus_master #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_width,
  input  logic        i_req_sign,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [1:0]  o_rsp_err,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic             r_we, r_sign;
  logic [1:0]       r_width, r_err;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hs, w_bad, w_timeout, w_issue, w_resp;
  logic [15:0]      w_half;
  logic [7:0]       w_byte;
  logic [31:0]      w_ext, w_wdata;
  logic [3:0]       w_be;
  assign w_hs      = i_req_valid && r_state == IDLE;
  assign w_bad     = i_req_width == 2'b11 ||
                     (i_req_width == 2'b00 && i_req_addr[1:0] != 2'b00) ||
                     (i_req_width == 2'b01 && i_req_addr[0]);
  assign w_timeout = r_cnt == CNT_W'(TIMEOUT - 1);
  assign w_issue   = r_state == ISSUE;
  assign w_resp    = r_state == RESP;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = w_bad ? RESP : ISSUE;
      ISSUE:   if (i_mem_gnt) w_next = WAIT;
      WAIT:    if (i_mem_rvalid || w_timeout) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  // Half lane picked by addr[1], then byte within it by addr[0]
  always_comb begin
    w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    w_byte = r_addr[0] ? w_half[15:8] : w_half[7:0];
    w_ext  = r_width == 2'b01 ? {{16{r_sign & w_half[15]}}, w_half} :
             r_width == 2'b10 ? {{24{r_sign & w_byte[7]}}, w_byte} : i_mem_rdata;
  end
  always_comb begin
    w_be    = r_width == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011) :
              r_width == 2'b10 ? 4'b0001 << r_addr[1:0] : 4'b1111;
    w_wdata = r_width == 2'b01 ? {2{r_wdata[15:0]}} :
              r_width == 2'b10 ? {4{r_wdata[7:0]}} : r_wdata;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_width <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      if (w_hs) begin
        r_we    <= i_req_we;
        r_sign  <= i_req_sign;
        r_width <= i_req_width;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_rdata <= '0;
        r_err   <= w_bad ? 2'b01 : 2'b00;
        r_cnt   <= '0;
      end
      if (r_state == WAIT) begin
        if (i_mem_rvalid)   r_rdata <= r_we ? 32'd0 : w_ext;
        else if (w_timeout) r_err   <= 2'b10;
        else                r_cnt   <= r_cnt + 1'b1;
      end
    end
  assign o_req_ready = r_state == IDLE;
  assign o_mem_req   = w_issue;
  assign o_mem_we    = w_issue & r_we;
  assign o_mem_addr  = w_issue ? {r_addr[31:2], 2'b00} : 32'd0;
  assign o_mem_be    = w_issue ? w_be : 4'd0;
  assign o_mem_wdata = (w_issue && r_we) ? w_wdata : 32'd0;
  assign o_rsp_valid = w_resp;
  assign o_rsp_rdata = w_resp ? r_rdata : 32'd0;
  assign o_rsp_err   = w_resp ? r_err : 2'b00;
endmodule
